// File: rtl/cp0_regfile_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception
// type encodings from the exception unit, ExcCode values and field positions.
package cp0_regfile_pkg;

    // CP0 register numbers (rd field of mtc0/mfc0)
    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    // Exception types committed by the exception unit
    localparam logic [31:0] ExcTypeNone = 32'h0;
    localparam logic [31:0] ExcTypeInt  = 32'h1;
    localparam logic [31:0] ExcTypeAdel = 32'h4;
    localparam logic [31:0] ExcTypeAdes = 32'h5;
    localparam logic [31:0] ExcTypeSys  = 32'h8;
    localparam logic [31:0] ExcTypeBp   = 32'h9;
    localparam logic [31:0] ExcTypeRi   = 32'hA;
    localparam logic [31:0] ExcTypeOv   = 32'hC;
    localparam logic [31:0] ExcTypeEret = 32'hE;

    // Architectural ExcCode values written to Cause[6:2]
    localparam logic [4:0] ExcCodeInt  = 5'h00;
    localparam logic [4:0] ExcCodeAdel = 5'h04;
    localparam logic [4:0] ExcCodeAdes = 5'h05;
    localparam logic [4:0] ExcCodeSys  = 5'h08;
    localparam logic [4:0] ExcCodeBp   = 5'h09;
    localparam logic [4:0] ExcCodeRi   = 5'h0A;
    localparam logic [4:0] ExcCodeOv   = 5'h0C;

    // Field positions and mtc0-writable masks
    localparam int unsigned StatusExlBit = 1;
    localparam int unsigned CauseBdBit   = 31;
    localparam int unsigned CauseIpHiLsb = 10;
    localparam int unsigned CauseExcLsb  = 2;
    localparam logic [31:0] StatusWmask  = 32'h0000_FF03;
    localparam logic [31:0] CauseWmask   = 32'h0000_0300;

    // Unknown nonzero exception types are treated as reserved instruction
    function automatic logic [4:0] exc_code_of(input logic [31:0] exc_type);
        logic [4:0] code;
        case (exc_type)
            ExcTypeInt:  code = ExcCodeInt;
            ExcTypeAdel: code = ExcCodeAdel;
            ExcTypeAdes: code = ExcCodeAdes;
            ExcTypeSys:  code = ExcCodeSys;
            ExcTypeBp:   code = ExcCodeBp;
            ExcTypeOv:   code = ExcCodeOv;
            default:     code = ExcCodeRi;
        endcase
        return code;
    endfunction

    function automatic logic is_addr_exc(input logic [31:0] exc_type);
        return (exc_type == ExcTypeAdel) || (exc_type == ExcTypeAdes);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// mtc0/mfc0 access bus between the pipeline (master) and CP0 (slave).
interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output we_i,
        output waddr_i,
        output raddr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  we_i,
        input  waddr_i,
        input  raddr_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match and timer interrupt flag.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    logic        div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;
    logic        tick;

    // With COUNT_DIV=1 Count advances every cycle; otherwise on every second cycle
    assign tick = (COUNT_DIV == 1) ? 1'b1 : div_q;

    // Next-state: divider, Count (mtc0 beats the increment), Compare, match flag
    always_comb begin
        div_d       = tick ? 1'b0 : 1'b1;
        count_d     = count_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
        if ((compare_q != 32'h0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end
        // Writing Compare acknowledges the interrupt, even against a fresh match
        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= 1'b0;
            count_q     <= 32'h0;
            compare_q   <= 32'h0;
            timer_int_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;
endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: mtc0/mfc0 access, interrupt sampling and
// exception/eret state capture. Count/Compare live in cp0_timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic                clk,
    input  logic                rst,
    cp0_regfile_if.slave        bus,
    input  logic [5:0]          int_i,
    input  logic [31:0]         excepttype_i,
    input  logic [31:0]         pc_i,
    input  logic                in_delayslot_i,
    input  logic [31:0]         badaddr_i,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic [31:0]         count_o,
    output logic [31:0]         compare_o,
    output logic [31:0]         badvaddr_o,
    output logic                timer_int_o
);
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        count_we, compare_we;
    logic        timer_int;
    logic [31:0] count, compare;
    logic [31:0] rdata;

    assign count_we   = bus.we_i && (bus.waddr_i == RegCount);
    assign compare_we = bus.we_i && (bus.waddr_i == RegCompare);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (bus.data_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );

    // Next-state: mtc0 first, then interrupt sampling, then exception capture on top
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (bus.we_i) begin
            case (bus.waddr_i)
                RegStatus: status_d = (status_q & ~StatusWmask) | (bus.data_i & StatusWmask);
                RegCause:  cause_d  = (cause_q & ~CauseWmask) | (bus.data_i & CauseWmask);
                RegEpc:    epc_d    = bus.data_i;
                default:   ;
            endcase
        end

        cause_d[CauseIpHiLsb +: 6] = {int_i[5] | timer_int, int_i[4:0]};

        if (excepttype_i == ExcTypeEret) begin
            status_d[StatusExlBit] = 1'b0;
        end else if (excepttype_i != ExcTypeNone) begin
            // Nested exceptions keep the original return point and BD flag
            if (!status_q[StatusExlBit]) begin
                epc_d               = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_d[CauseBdBit] = in_delayslot_i;
            end
            status_d[StatusExlBit]    = 1'b1;
            cause_d[CauseExcLsb +: 5] = exc_code_of(excepttype_i);
            if (is_addr_exc(excepttype_i)) begin
                badvaddr_d = badaddr_i;
            end
        end
    end

    // Architectural state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= RESET_STATUS;
            cause_q    <= 32'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // mfc0 read with same-cycle forwarding of the masked mtc0 value
    always_comb begin
        rdata = 32'h0;
        case (bus.raddr_i)
            RegBadVAddr: rdata = badvaddr_q;
            RegCount:    rdata = count;
            RegCompare:  rdata = compare;
            RegStatus:   rdata = status_q;
            RegCause:    rdata = cause_q;
            RegEpc:      rdata = epc_q;
            default:     rdata = 32'h0;
        endcase
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.waddr_i)
                RegCount, RegCompare, RegEpc: rdata = bus.data_i;
                RegStatus: rdata = (status_q & ~StatusWmask) | (bus.data_i & StatusWmask);
                RegCause:  rdata = (cause_q & ~CauseWmask) | (bus.data_i & CauseWmask);
                default:   ;
            endcase
        end
    end

    assign bus.data_o  = rdata;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count;
    assign compare_o   = compare;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_int;
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the 5-stage MIPS core.
- Consumes the write-back-stage CP0 write strobe (cp0writeW) that the pipeline controller produces. Serves mfc0 reads.
- Runs the Count/Compare timer and latches interrupt lines.
- Records exception state (EPC, Cause, Status.EXL, BadVAddr) when the exception unit commits an exception or eret.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1 or 2 only).
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- we_i  in  1  CP0 write enable from the write-back stage (cp0writeW).
- waddr_i  in  5  destination CP0 register number (rd of mtc0).
- raddr_i  in  5  source CP0 register number (rd of mfc0).
- data_i  in  32  mtc0 write data.
- int_i  in  6  external hardware interrupt lines, level-sensitive.
- excepttype_i  in  32  committed exception code from the exception unit; 0 means none.
- pc_i  in  32  PC of the excepting instruction.
- in_delayslot_i  in  1  excepting instruction sits in a branch delay slot.
- badaddr_i  in  32  faulting address for AdEL/AdES.
- data_o  out  32  mfc0 read data.
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  architectural register values.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
- Reset (rst=1 at clk edge): Status=RESET_STATUS. Cause, EPC, Count, Compare and BadVAddr =0. timer_int_o=0. Internal divider =0. Reset overrides all other inputs.
- Register map: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Writes to other numbers are ignored; reads return 0.
- Writable fields:
  - Count, Compare, EPC: all 32 bits.
  - Status: [15:8] IM, [1] EXL, [0] IE. All other bits hold.
  - Cause: [9:8] software IP only.
- Read path: combinational from registers. If we_i=1 and waddr_i==raddr_i, data_o returns the write-masked new value (write forwarding).
- Count timer:
  - Divider counts 0..COUNT_DIV-1. Count += 1 when the divider wraps. Count wraps 0xFFFF_FFFF→0.
  - An mtc0 write to Count in the same cycle wins over the increment.
- Timer interrupt:
  - timer_int_o is set the cycle after Compare!=0 and Count==Compare.
  - It is cleared by any mtc0 to Compare. If the set and clear conditions occur in the same cycle, the clear wins.
- Interrupt sampling: every cycle, Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]}. mtc0 cannot write these bits.
- Exception commit (excepttype_i!=0), applied after the mtc0 update in the same cycle (exception fields win):
  - Codes 0x1 Int→ExcCode 0x00, 0x4 AdEL→0x04, 0x5 AdES→0x05, 0x8 Sys→0x08, 0x9 Bp→0x09, 0xA RI→0x0A, 0xC Ov→0x0C.
  - If Status.EXL=0: EPC <= in_delayslot_i ? pc_i-4 : pc_i, and Cause[31] (BD) <= in_delayslot_i. If EXL=1 already, EPC and BD hold.
  - Status.EXL <= 1. Cause[6:2] <= ExcCode.
  - For AdEL/AdES only: BadVAddr <= badaddr_i.
  - 0xE eret: Status.EXL <= 0 only.
  - Any other nonzero code: ExcCode 0x0A (RI) treatment.
- Latency: writes are visible on outputs one cycle after the edge. data_o is zero-latency via forwarding.

Decomposition:
- Shared package holds: CP0 register numbers (8/9/11/12/13/14), excepttype encodings, ExcCode values, Status/Cause bit-position constants.
- One natural sub-module: cp0_timer, holding the divider, Count/Compare and timer_int_o logic.

Test Plan:
- Reset, then read 12 → data_o=0x0040_0000. Read 9 on the same edge → 0.
- COUNT_DIV=2, idle 10 cycles → count_o=5. mtc0 9 ← 0xFFFF_FFFF, wait 2 cycles → count_o=0 (wrap).
- mtc0 11 ← 0x10 with Count=0x0E → timer_int_o=1 once Count reaches 0x10, then cause_o[15]=1 the next cycle. mtc0 11 ← 0x20 → timer_int_o=0.
- excepttype_i=0xC, pc_i=0xBFC0_0100, in_delayslot_i=1, EXL=0 → epc_o=0xBFC0_00FC, cause_o[31]=1, cause_o[6:2]=0x0C, status_o[1]=1.
- Second exception 0x4 with EXL=1, badaddr_i=0x1233 → EPC unchanged, badvaddr_o=0x1233, ExcCode=0x04. Then excepttype_i=0xE → status_o[1]=0.
- Same cycle: we_i=1, waddr_i=raddr_i=14, data_i=0xDEAD_BEEF → data_o=0xDEAD_BEEF combinationally. Same cycle with excepttype_i=0x8, EXL=0 → epc_o=pc_i after the edge (exception wins).
